// File: rtl/filter_buffer_pkg.sv
// filter_buffer_pkg: shared filter-buffer widths and controller state encodings.
package filter_buffer_pkg;
    localparam int FILTER_DW         = 72;
    localparam int FILTER_BUFFER_AW  = 10;
    localparam int FILTER_BUFFER_CNT = 4;
    localparam int Tout              = 4;
    typedef enum logic [1:0] {
        FB_IDLE  = 2'd0,
        FB_LOAD  = 2'd1,
        FB_READY = 2'd2
    } fb_state_t;
endpackage

// File: rtl/filter_bank_ram.sv
// filter_bank_ram: one filter bank, single write port, registered read that holds when idle.
module filter_bank_ram
    import filter_buffer_pkg::*;
#(
    parameter int DW = FILTER_DW,
    parameter int AW = FILTER_BUFFER_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    // Only the read register is reset; bank contents survive rst.
    always_ff @(posedge clk) begin
        if (rst) o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/filter_buffer.sv
// filter_buffer: loads one output-channel group into four banks, then serves PE filter reads.
module filter_buffer
    import filter_buffer_pkg::*;
#(
    parameter int FILTER_DW     = filter_buffer_pkg::FILTER_DW,
    parameter int FILTER_BUF_AW = FILTER_BUFFER_AW,
    parameter int NB_FILTER     = FILTER_BUFFER_CNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load_start,
    input  logic [FILTER_BUF_AW:0]   i_load_len,
    input  logic                     i_wr_vld,
    input  logic [FILTER_DW-1:0]     i_wr_data,
    output logic                     o_wr_rdy,
    input  logic                     i_release,
    output logic                     o_fb_req_possible,
    input  logic                     i_fb_req,
    input  logic [FILTER_BUF_AW-1:0] i_fb_addr,
    output logic [FILTER_DW-1:0]     o_fb_data0,
    output logic [FILTER_DW-1:0]     o_fb_data1,
    output logic [FILTER_DW-1:0]     o_fb_data2,
    output logic [FILTER_DW-1:0]     o_fb_data3,
    output logic                     o_load_done,
    output logic                     o_err
);
    fb_state_t                r_state, w_state_nxt;
    logic [FILTER_BUF_AW:0]   r_len;
    logic [1:0]               r_bank_sel;
    logic [FILTER_BUF_AW-1:0] r_wr_addr;
    logic                     r_load_done, r_err;
    logic                     w_xfer, w_last, w_len_bad, w_start_ok, w_err;
    logic [FILTER_DW-1:0]     w_rdata [NB_FILTER];

    assign w_xfer     = i_wr_vld & o_wr_rdy;
    assign w_last     = w_xfer && r_bank_sel == 2'd3 &&
                        {1'b0, r_wr_addr} == r_len - (FILTER_BUF_AW+1)'(1);
    assign w_len_bad  = i_load_len == '0 || i_load_len > {1'b1, {FILTER_BUF_AW{1'b0}}};
    assign w_start_ok = r_state == FB_IDLE && i_load_start && !w_len_bad;
    assign w_err      = (r_state == FB_IDLE && i_load_start && w_len_bad) ||
                        (r_state == FB_LOAD && i_load_start) ||
                        (i_fb_req && (r_state != FB_READY || {1'b0, i_fb_addr} >= r_len)) ||
                        (i_release && r_state != FB_READY);

    always_comb begin
        w_state_nxt       = r_state;
        o_wr_rdy          = r_state == FB_LOAD;
        o_fb_req_possible = r_state == FB_READY;
        w_state_nxt = r_state == FB_IDLE  ? (w_start_ok ? FB_LOAD : FB_IDLE) :
                      r_state == FB_LOAD  ? (w_last ? FB_READY : FB_LOAD) :
                      r_state == FB_READY ? (i_release ? FB_IDLE : FB_READY) : FB_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FB_IDLE;
            r_len       <= '0;
            r_bank_sel  <= '0;
            r_wr_addr   <= '0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_done <= w_last;
            r_err       <= r_err | w_err;
            if (w_start_ok) begin
                r_len      <= i_load_len;
                r_bank_sel <= '0;
                r_wr_addr  <= '0;
            end else if (w_xfer) begin
                // Bank-inner order: word n lands in bank n%4 at address n/4.
                r_bank_sel <= r_bank_sel + 2'd1;
                if (r_bank_sel == 2'd3) r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NB_FILTER; b++) begin : g_bank
        filter_bank_ram #(.DW(FILTER_DW), .AW(FILTER_BUF_AW)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_xfer && r_bank_sel == 2'(b)),
            .i_waddr (r_wr_addr),
            .i_wdata (i_wr_data),
            .i_re    (i_fb_req),
            .i_raddr (i_fb_addr),
            .o_rdata (w_rdata[b])
        );
    end

    assign o_fb_data0  = w_rdata[0];
    assign o_fb_data1  = w_rdata[1];
    assign o_fb_data2  = w_rdata[2];
    assign o_fb_data3  = w_rdata[3];
    assign o_load_done = r_load_done;
    assign o_err       = r_err;
endmodule

// File: tb/tb_filter_buffer.sv
// tb_filter_buffer: randomized load/read stimulus with a scoreboard against a bank-array model.
module tb_filter_buffer;
    localparam int DW    = 72;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 0, rst = 1, ls = 0, vld = 0, rel = 0, req = 0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] addr = '0;
    logic          wr_rdy, req_poss, done, err;
    logic [DW-1:0] d0, d1, d2, d3;

    always #5 clk = ~clk;

    filter_buffer dut (
        .clk (clk), .rst (rst), .i_load_start (ls), .i_load_len (len),
        .i_wr_vld (vld), .i_wr_data (wdata), .o_wr_rdy (wr_rdy), .i_release (rel),
        .o_fb_req_possible (req_poss), .i_fb_req (req), .i_fb_addr (addr),
        .o_fb_data0 (d0), .o_fb_data1 (d1), .o_fb_data2 (d2), .o_fb_data3 (d3),
        .o_load_done (done), .o_err (err)
    );

    int              n_chk = 0, n_fail = 0;
    logic [DW-1:0]   model [4][DEPTH];
    logic [DW-1:0]   wq [$];
    logic [4*DW-1:0] exp_q [$];
    logic            pend = 0;

    task automatic chk(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a request sampled at an edge owes one result after that edge.
    always @(posedge clk) pend <= req & ~rst;
    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h expected no read result", {d3, d2, d1, d0});
            end else chk("rd_data", {d3, d2, d1, d0}, exp_q.pop_front());
        end
    end

    task automatic idle();
        @(negedge clk);
        vld = 0; req = 0; rel = 0; ls = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        vld = 0; req = 0; rel = 0; ls = 0; rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic fill(input int l, input int mode);
        wq.delete();
        for (int n = 0; n < 4 * l; n++)
            wq.push_back(mode == 0 ? DW'(n) : mode == 1 ? DW'(32'h100 + n) :
                         DW'({$urandom, $urandom, $urandom}));
    endtask

    task automatic start(input int l);
        @(negedge clk);
        vld = 0; req = 0; rel = 0; ls = 1; len = l[AW:0];
        @(negedge clk);
        ls = 0;
    endtask

    task automatic send(input int from, input int to);
        int g;
        bit ok;
        for (int n = from; n < to; n++) begin
            g = 0;
            ok = 0;
            while (!ok) begin
                @(negedge clk);
                req = 0; rel = 0;
                vld = $urandom_range(0, 2) != 0;
                wdata = wq[n];
                ok = vld && wr_rdy;
                g++;
                if (!ok && g > 64) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wr_rdy_timeout word %0d: got rdy=%b required 1", n, wr_rdy);
                    vld = 0;
                    return;
                end
            end
            model[n % 4][n / 4] = wq[n];
        end
    endtask

    task automatic finish_load();
        @(negedge clk);
        vld = 0;
        chk("load_done", done, 1);
        chk("req_possible", req_poss, 1);
        chk("wr_rdy_after_load", wr_rdy, 0);
        @(negedge clk);
        chk("load_done_pulse", done, 0);
    endtask

    task automatic load(input int l, input int mode);
        fill(l, mode);
        start(l);
        send(0, 4 * l);
        finish_load();
    endtask

    task automatic rd(input int a, input bit with_rel);
        @(negedge clk);
        vld = 0; ls = 0; rel = with_rel; req = 1; addr = a[AW-1:0];
        exp_q.push_back({model[3][a], model[2][a], model[1][a], model[0][a]});
    endtask

    task automatic release_grp();
        @(negedge clk);
        req = 0; rel = 1;
        @(negedge clk);
        rel = 0;
        chk("req_possible_released", req_poss, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_wr_rdy", wr_rdy, 0);
        chk("rst_req_possible", req_poss, 0);
        chk("rst_load_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_data", {d3, d2, d1, d0}, 0);

        load(4, 0);
        for (int a = 0; a < 4; a++) rd(a, 0);
        idle();
        idle();
        chk("err_clean_reads", err, 0);
        chk("data_hold", {d3, d2, d1, d0}, {model[3][3], model[2][3], model[1][3], model[0][3]});

        release_grp();
        load(2, 1);
        rd(1, 0);
        rd(0, 1);
        @(negedge clk);
        req = 0; rel = 0;
        chk("req_possible_rel_with_read", req_poss, 0);
        chk("err_second_group", err, 0);

        load(DEPTH, 2);
        rd(DEPTH - 1, 0);
        rd(0, 0);
        rd(512, 0);
        idle();
        chk("err_full_depth", err, 0);
        release_grp();

        load(4, 0);
        rd(5, 0);
        idle();
        chk("err_addr_over_len", err, 1);
        release_grp();

        do_reset();
        chk("err_cleared_by_rst", err, 0);
        fill(4, 2);
        start(4);
        send(0, 2);
        rd(0, 0);
        idle();
        chk("err_read_in_load", err, 1);
        send(2, 16);
        finish_load();
        chk("err_sticky", err, 1);

        fill(4, 2);
        release_grp();
        start(4);
        send(0, 6);
        @(negedge clk);
        vld = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midload_rst_wr_rdy", wr_rdy, 0);
        chk("midload_rst_req_possible", req_poss, 0);
        chk("midload_rst_load_done", done, 0);
        chk("midload_rst_err", err, 0);
        chk("midload_rst_data", {d3, d2, d1, d0}, 0);
        load(1, 2);
        rd(0, 0);
        idle();
        chk("err_after_fresh_load", err, 0);

        release_grp();
        @(negedge clk);
        rel = 1;
        @(negedge clk);
        rel = 0;
        chk("err_release_idle", err, 1);

        do_reset();
        start(0);
        chk("err_len_zero", err, 1);
        chk("wr_rdy_len_zero", wr_rdy, 0);
        do_reset();
        start(DEPTH + 1);
        chk("err_len_over", err, 1);
        chk("wr_rdy_len_over", wr_rdy, 0);
        do_reset();
        start(DEPTH);
        chk("wr_rdy_len_max", wr_rdy, 1);
        chk("err_len_max", err, 0);

        idle();
        idle();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
